// File: rtl/adc_scan_pkg.sv
// adc_scan_pkg: scan FSM state encoding, per-channel mux select codes and default widths
package adc_scan_pkg;
   typedef enum logic [2:0] {IDLE, SELECT, SETTLE, ACQUIRE, OUTPUT} state_e;
   localparam int NUM_CH_DEF = 4;
   localparam int SEL_W_DEF  = 4;
   // Channels 0..3 use the ACM9226 mux codes; higher entries take the remaining codes.
   localparam logic [15:0][3:0] CH_SEL = {4'd15, 4'd14, 4'd12, 4'd11, 4'd9, 4'd8, 4'd7, 4'd5,
                                          4'd4, 4'd3, 4'd1, 4'd0, 4'd13, 4'd10, 4'd6, 4'd2};
endpackage

// File: rtl/adc_ch_pick.sv
// adc_ch_pick: next enabled channel strictly above cur (or lowest when cur is "none"), with wrap flag
module adc_ch_pick #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
) (
   input  logic [NUM_CH-1:0] mask_i,
   input  logic [CH_W-1:0]   cur_i,
   input  logic              cur_vld_i,
   output logic [CH_W-1:0]   nxt_o,
   output logic              found_o,
   output logic              wrap_o
);
   logic [CH_W-1:0] lo, hi;
   logic            lo_f, hi_f;
   always_comb begin
      lo   = '0;
      hi   = '0;
      lo_f = 1'b0;
      hi_f = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            lo   = CH_W'(i);
            lo_f = 1'b1;
         end
         if (mask_i[i] && cur_vld_i && i > int'(cur_i)) begin
            hi   = CH_W'(i);
            hi_f = 1'b1;
         end
      end
      found_o = lo_f;
      nxt_o   = hi_f ? hi : lo;
      wrap_o  = lo_f && cur_vld_i && !hi_f;
   end
endmodule

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: mask-aware, settle-timed ADC channel scanner with a valid/ready result stream.
// Define ADC_SCAN_AVG_EN to average 2^AVG_LOG2 samples per channel instead of taking the first one.
module adc_scan_sequencer
   import adc_scan_pkg::*;
#(
   parameter  int NUM_CH     = NUM_CH_DEF,
   parameter  int SEL_W      = SEL_W_DEF,
   parameter  int DATA_W     = 12,
   parameter  int SETTLE_CYC = 8,
   parameter  int AVG_LOG2   = 2,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              ss_Clk,
   input  logic              ss_Rst,
   input  logic              ss_En,
   input  logic [NUM_CH-1:0] ss_ChMask,
   input  logic [DATA_W-1:0] ss_AdcData,
   input  logic              ss_AdcValid,
   output logic [SEL_W-1:0]  ss_MuxSel,
   output logic [DATA_W-1:0] ss_Data,
   output logic [CH_W-1:0]   ss_Ch,
   output logic              ss_Valid,
   input  logic              ss_Ready,
   output logic              ss_Busy,
   output logic              ss_ScanDone
);
   localparam int CNT_W = $clog2(SETTLE_CYC) + 1;
   state_e            state_q, state_d;
   logic [CH_W-1:0]   cur_q, cur_d, ch_q, ch_d, pk_nxt;
   logic [SEL_W-1:0]  mux_q, mux_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d, done_q, done_d, pk_found, pk_wrap, single;
`ifdef ADC_SCAN_AVG_EN
   localparam int ACC_W = DATA_W + AVG_LOG2;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [AVG_LOG2-1:0] smp_q, smp_d;
`endif

   // Outside OUTPUT the search has no current channel, so it yields the lowest set bit.
   adc_ch_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick (
      .mask_i   (ss_ChMask),
      .cur_i    (cur_q),
      .cur_vld_i(state_q == OUTPUT),
      .nxt_o    (pk_nxt),
      .found_o  (pk_found),
      .wrap_o   (pk_wrap)
   );

   assign single = (ss_ChMask != '0) && ((ss_ChMask & (ss_ChMask - 1'b1)) == '0);

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      mux_d   = mux_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      ch_d    = ch_q;
      valid_d = valid_q;
      done_d  = 1'b0;
`ifdef ADC_SCAN_AVG_EN
      acc_d   = acc_q;
      smp_d   = smp_q;
`endif
      unique case (state_q)
         IDLE: begin
            state_d = (ss_En && pk_found) ? SELECT : IDLE;
            cur_d   = (ss_En && pk_found) ? pk_nxt : cur_q;
         end
         SELECT: begin
            state_d = SETTLE;
            mux_d   = SEL_W'(CH_SEL[cur_q]);
            cnt_d   = CNT_W'(SETTLE_CYC - 1);
`ifdef ADC_SCAN_AVG_EN
            acc_d   = '0;
            smp_d   = '0;
`endif
         end
         SETTLE: begin
            state_d = (cnt_q == '0) ? ACQUIRE : SETTLE;
            cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
         end
         ACQUIRE: if (ss_AdcValid && ss_En) begin
`ifdef ADC_SCAN_AVG_EN
            acc_d = acc_q + ACC_W'(ss_AdcData);
            smp_d = smp_q + 1'b1;
            if (&smp_q) begin
               state_d = OUTPUT;
               data_d  = acc_d[ACC_W-1:AVG_LOG2];
               ch_d    = cur_q;
               valid_d = 1'b1;
            end
`else
            state_d = OUTPUT;
            data_d  = ss_AdcData;
            ch_d    = cur_q;
            valid_d = 1'b1;
`endif
         end
         OUTPUT: if (ss_Ready) begin
            valid_d = 1'b0;
            done_d  = pk_wrap || single;
            cur_d   = pk_found ? pk_nxt : cur_q;
            state_d = (ss_En && pk_found) ? SELECT : IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A dropped enable abandons any acquisition that has not yet produced a result.
      if (!ss_En && state_q inside {SELECT, SETTLE, ACQUIRE}) state_d = IDLE;
      mux_d = (state_d == IDLE) ? SEL_W'(CH_SEL[0]) : mux_d;
   end

   always_ff @(posedge ss_Clk or negedge ss_Rst) begin
      if (!ss_Rst) begin
         state_q <= IDLE;
         cur_q   <= '0;
         mux_q   <= SEL_W'(CH_SEL[0]);
         cnt_q   <= '0;
         data_q  <= '0;
         ch_q    <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
         acc_q   <= '0;
         smp_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         mux_q   <= mux_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         ch_q    <= ch_d;
         valid_q <= valid_d;
         done_q  <= done_d;
`ifdef ADC_SCAN_AVG_EN
         acc_q   <= acc_d;
         smp_q   <= smp_d;
`endif
      end
   end

   assign ss_MuxSel   = mux_q;
   assign ss_Data     = data_q;
   assign ss_Ch       = ch_q;
   assign ss_Valid    = valid_q;
   assign ss_ScanDone = done_q;
   assign ss_Busy     = state_q != IDLE;
endmodule
